// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes and requester count for the arbitrated ALU.
package alu_pkg;

    localparam int unsigned NUM_REQ = 2;

    localparam logic [2:0] ALU_Add = 3'd0;
    localparam logic [2:0] ALU_Sub = 3'd1;
    localparam logic [2:0] ALU_And = 3'd2;
    localparam logic [2:0] ALU_SLL = 3'd3;
    localparam logic [2:0] ALU_SLR = 3'd4;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU: add, sub, and, logical shifts, plus zero/negative flags.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg
);

    always_comb begin
        result = '0;
        case (op)
            ALU_Add: result = a + b;
            ALU_Sub: result = a - b;
            ALU_And: result = a & b;
            ALU_SLL: result = a << b[4:0];
            ALU_SLR: result = a >> b[4:0];
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);
    assign neg  = result[WIDTH-1];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the execute stage (0)
// and the branch/address unit (1), with a registered response slot per requester.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req0_op,
    input  logic [2:0]       req1_op,
    output logic [1:0]       rsp_valid_o,
    input  logic [1:0]       rsp_ready_i,
    output logic [WIDTH-1:0] rsp0_result,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp0_zero,
    output logic             rsp1_zero,
    output logic             rsp0_neg,
    output logic             rsp1_neg,
    output logic [CNT_W-1:0] conflict_count
);

    logic [NUM_REQ-1:0] slot_free;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic               rr_ptr;
    logic [CNT_W-1:0]   conflict_q;

    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [2:0]         alu_op;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_zero;
    logic               alu_neg;

    // A slot draining this cycle can be refilled on the same edge.
    assign slot_free = ~rsp_valid_o | rsp_ready_i;
    assign eligible  = req_valid_i & slot_free;

    always_comb begin
        grant = '0;
        if (eligible == 2'b11) begin
            grant[rr_ptr] = 1'b1;
        end else begin
            grant = eligible;
        end
    end

    assign req_ready_o = grant;

    // Requester 0 is the default mux leg when nobody is granted.
    assign alu_a  = grant[1] ? req1_a  : req0_a;
    assign alu_b  = grant[1] ? req1_b  : req0_b;
    assign alu_op = grant[1] ? req1_op : req0_op;

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero),
        .neg    (alu_neg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= 1'b0;
            conflict_q <= '0;
        end else begin
            if (grant[0]) begin
                rr_ptr <= 1'b1;
            end else if (grant[1]) begin
                rr_ptr <= 1'b0;
            end
            if (eligible == 2'b11 && conflict_q != '1) begin
                conflict_q <= conflict_q + 1'b1;
            end
        end
    end

    assign conflict_count = conflict_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : gen_rsp
        logic             valid_q;
        logic [WIDTH-1:0] result_q;
        logic             zero_q;
        logic             neg_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q  <= 1'b0;
                result_q <= '0;
                zero_q   <= 1'b0;
                neg_q    <= 1'b0;
            end else if (grant[i]) begin
                valid_q  <= 1'b1;
                result_q <= alu_result;
                zero_q   <= alu_zero;
                neg_q    <= alu_neg;
            end else if (rsp_ready_i[i]) begin
                valid_q  <= 1'b0;
            end
        end
    end

    assign rsp_valid_o = {gen_rsp[1].valid_q, gen_rsp[0].valid_q};
    assign rsp0_result = gen_rsp[0].result_q;
    assign rsp1_result = gen_rsp[1].result_q;
    assign rsp0_zero   = gen_rsp[0].zero_q;
    assign rsp1_zero   = gen_rsp[1].zero_q;
    assign rsp0_neg    = gen_rsp[0].neg_q;
    assign rsp1_neg    = gen_rsp[1].neg_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a per-requester scoreboard.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid_i;
    logic [1:0]       req_ready_o;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]       req0_op, req1_op;
    logic [1:0]       rsp_valid_o;
    logic [1:0]       rsp_ready_i;
    logic [WIDTH-1:0] rsp0_result, rsp1_result;
    logic             rsp0_zero, rsp1_zero, rsp0_neg, rsp1_neg;
    logic [CNT_W-1:0] conflict_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH+1:0] q0[$];
    logic [WIDTH+1:0] q1[$];
    logic [WIDTH+1:0] exp0, exp1;

    alu_arbiter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req0_a         (req0_a),
        .req0_b         (req0_b),
        .req1_a         (req1_a),
        .req1_b         (req1_b),
        .req0_op        (req0_op),
        .req1_op        (req1_op),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp0_result    (rsp0_result),
        .rsp1_result    (rsp1_result),
        .rsp0_zero      (rsp0_zero),
        .rsp1_zero      (rsp1_zero),
        .rsp0_neg       (rsp0_neg),
        .rsp1_neg       (rsp1_neg),
        .conflict_count (conflict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model, returns {neg, zero, result}.
    function automatic logic [WIDTH+1:0] model(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a << b[4:0];
            3'd4:    r = a >> b[4:0];
            default: r = '0;
        endcase
        return {r[WIDTH-1], (r == '0), r};
    endfunction

    // Scoreboard: push on request handshake, pop on response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid_o[0] && rsp_ready_i[0]) begin
                if (q0.size() == 0) begin
                    check("sb0_underflow", 64'd1, 64'd0);
                end else begin
                    exp0 = q0.pop_front();
                    check("sb0_rsp", 64'({rsp0_neg, rsp0_zero, rsp0_result}), 64'(exp0));
                end
            end
            if (rsp_valid_o[1] && rsp_ready_i[1]) begin
                if (q1.size() == 0) begin
                    check("sb1_underflow", 64'd1, 64'd0);
                end else begin
                    exp1 = q1.pop_front();
                    check("sb1_rsp", 64'({rsp1_neg, rsp1_zero, rsp1_result}), 64'(exp1));
                end
            end
            if (req_valid_i[0] && req_ready_o[0]) q0.push_back(model(req0_op, req0_a, req0_b));
            if (req_valid_i[1] && req_ready_o[1]) q1.push_back(model(req1_op, req1_a, req1_b));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        req_valid_i = 2'b00;
        q0.delete();
        q1.delete();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set0(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req0_op = op;
        req0_a  = a;
        req0_b  = b;
    endtask

    task automatic set1(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req1_op = op;
        req1_a  = a;
        req1_b  = b;
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b11;
        set0(ALU_Add, '0, '0);
        set1(ALU_Add, '0, '0);
        repeat (2) tick();
        check("rst_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_result0", 64'(rsp0_result), 64'd0);
        check("rst_count", 64'(conflict_count), 64'd0);
        rst_n = 1'b1;

        // Single request on requester 0
        set0(ALU_Add, 32'd10, 32'd20);
        req_valid_i = 2'b01;
        #1 check("t1_ready", 64'(req_ready_o), 64'h1);
        tick();
        req_valid_i = 2'b00;
        check("t1_valid", 64'(rsp_valid_o), 64'h1);
        check("t1_result", 64'(rsp0_result), 64'd30);
        check("t1_flags", 64'({rsp0_zero, rsp0_neg}), 64'd0);
        check("t1_count", 64'(conflict_count), 64'd0);

        // Contention from reset: requester 0 first, then 1
        do_reset();
        set0(ALU_Sub, 32'd30, 32'd20);
        set1(ALU_And, 32'hF0F, 32'hFFF);
        req_valid_i = 2'b11;
        #1 check("t2_grant0", 64'(req_ready_o), 64'h1);
        tick();
        req_valid_i = 2'b10;
        check("t2_rsp0", 64'(rsp0_result), 64'd10);
        check("t2_valid0", 64'(rsp_valid_o), 64'h1);
        #1 check("t2_grant1", 64'(req_ready_o), 64'h2);
        tick();
        req_valid_i = 2'b00;
        check("t2_rsp1", 64'(rsp1_result), 64'hF0F);
        check("t2_valid1", 64'(rsp_valid_o), 64'h2);
        check("t2_count", 64'(conflict_count), 64'd1);

        // Backpressure on requester 0
        rsp_ready_i = 2'b10;
        set0(ALU_Sub, 32'd50, 32'd50);
        req_valid_i = 2'b01;
        tick();
        check("t3_rsp0", 64'({rsp0_zero, rsp0_result}), 64'({1'b1, 32'd0}));
        set0(ALU_Add, 32'd1, 32'd2);
        set1(ALU_SLL, 32'hF0F, 32'd4);
        req_valid_i = 2'b11;
        #1 check("t3_grant1", 64'(req_ready_o), 64'h2);
        tick();
        req_valid_i = 2'b01;
        check("t3_rsp1", 64'(rsp1_result), 64'hF0F0);
        check("t3_hold0", 64'({rsp0_zero, rsp0_result}), 64'({1'b1, 32'd0}));
        #1 check("t3_blocked", 64'(req_ready_o), 64'h0);
        tick();
        check("t3_hold0b", 64'({rsp_valid_o[0], rsp0_zero, rsp0_result}), 64'({2'b11, 32'd0}));
        check("t3_blocked_b", 64'(req_ready_o), 64'h0);
        rsp_ready_i = 2'b11;
        #1 check("t3_release", 64'(req_ready_o), 64'h1);
        tick();
        req_valid_i = 2'b00;
        check("t3_rsp0_new", 64'(rsp0_result), 64'd3);
        check("t3_count", 64'(conflict_count), 64'd1);

        // Negative result
        set0(ALU_Sub, 32'd50, 32'd100);
        req_valid_i = 2'b01;
        tick();
        req_valid_i = 2'b00;
        check("t4_result", 64'(rsp0_result), 64'hFFFF_FFCE);
        check("t4_flags", 64'({rsp0_neg, rsp0_zero}), 64'b10);

        // Back-to-back on requester 1
        set1(ALU_SLL, 32'hF0F, 32'd4);
        req_valid_i = 2'b10;
        #1 check("t5_ready_a", 64'(req_ready_o), 64'h2);
        tick();
        set1(ALU_SLR, 32'hF0F, 32'd4);
        check("t5_rsp_a", 64'({rsp_valid_o[1], rsp1_result}), 64'({1'b1, 32'hF0F0}));
        #1 check("t5_ready_b", 64'(req_ready_o), 64'h2);
        tick();
        req_valid_i = 2'b00;
        check("t5_rsp_b", 64'({rsp_valid_o[1], rsp1_result}), 64'({1'b1, 32'hF0}));

        // Build up two held responses and a count of 3, then reset mid-flight
        set0(ALU_Add, 32'd1, 32'd1);
        set1(ALU_Add, 32'd2, 32'd2);
        req_valid_i = 2'b11;
        tick();
        tick();
        rsp_ready_i = 2'b00;
        tick();
        req_valid_i = 2'b00;
        check("t6_valid_pre", 64'(rsp_valid_o), 64'h3);
        check("t6_count_pre", 64'(conflict_count), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid_rst", 64'(rsp_valid_o), 64'h0);
        check("t6_results_rst", 64'({rsp0_result, rsp1_result}), 64'd0);
        check("t6_count_rst", 64'(conflict_count), 64'd0);
        q0.delete();
        q1.delete();
        tick();
        rst_n = 1'b1;
        rsp_ready_i = 2'b11;
        set0(ALU_And, 32'hFF00, 32'h0FF0);
        set1(ALU_Sub, 32'd7, 32'd9);
        req_valid_i = 2'b11;
        #1 check("t6_first", 64'(req_ready_o), 64'h1);
        tick();
        check("t6_second", 64'(req_ready_o), 64'h2);
        tick();
        req_valid_i = 2'b00;
        repeat (3) tick();
        check("sb0_drained", 64'(q0.size()), 64'd0);
        check("sb1_drained", 64'(q1.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
